motion_seg_sched: RTL and testbench
===================================

# motion_seg_sched

Segment scheduler for one motion axis. It buffers motion segments (step period, step count, direction) from the host register/bus logic in a small FIFO. It sequences them into the axis's acceleration step generator back-to-back, with no idle cycles between segments, and tracks absolute axis position from the generated step strobes. It sits between the bus-facing control registers and the step generator. It owns the generator's `load` and `reset` inputs.

## Interface
- `FIFO_AW`, default 2: FIFO address width; the FIFO depth is 2^FIFO_AW segments.
- `clk`  in  1  Clock.
- `reset`  in  1  Synchronous, active-high.
- `seg_dt`  in  32  Segment step period in clocks; must be ≥1.
- `seg_steps`  in  32  Segment step count; must be ≥1.
- `seg_dir`  in  1  Segment direction: 1 = positive, 0 = negative.
- `seg_valid`  in  1  Push request.
- `seg_ready`  out  1  FIFO not full.
- `enable`  in  1  Level signal; allows segments to be issued.
- `abort`  in  1  Single-cycle pulse; stops motion and flushes the FIFO.
- `clear_err`  in  1  Clears `err_zero`.
- `gen_dt_val`  out  32  To generator `dt_val`; equals the FIFO head `dt`.
- `gen_steps_val`  out  32  To generator `steps_val`; equals the FIFO head `steps`.
- `gen_load`  out  1  To generator `load`; combinational.
- `gen_reset`  out  1  To generator `reset`; registered.
- `gen_step_stb`  in  1  From generator; combinational, high in the cycle a step completes.
- `gen_done`  in  1  From generator; combinational, high in the cycle of a segment's last step.
- `dir`  out  1  Direction of the segment currently running.
- `step`  out  1  Step pulse to the driver.
- `position`  out  32  Signed absolute position in steps.
- `busy`  out  1  State is not IDLE.
- `fifo_level`  out  FIFO_AW+1  Number of buffered segments.
- `seg_done_stb`  out  1  Single-cycle pulse, one cycle after `gen_done`.
- `err_zero`  out  1  Sticky flag: a segment was rejected.

## Operation
- **FIFO**
  - Width is 65 bits: `{dir, steps, dt}`.
  - A push occurs when `seg_valid && seg_ready`.
  - `seg_ready = (fifo_level != 2^FIFO_AW)`. It is not raised by a same-cycle pop.
  - A segment with `seg_dt==0` or `seg_steps==0` is handshaken (accepted) but not written, and `err_zero` is set. Such a segment would hang the generator.
  - A push and a pop in the same cycle are both honoured; `fifo_level` is unchanged.
- **States**
  - **IDLE**
    - `gen_load = enable && fifo_level!=0`.
    - On load: pop the head, capture its `dir` into the `dir` register, go to RUN.
  - **RUN**
    - `gen_load = gen_done && enable && fifo_level!=0`, giving a chained load.
    - On a chained load: pop, capture `dir`, stay in RUN.
    - On `gen_done` without a load: go to IDLE.
  - **FLUSH**
    - Entered from any state on `abort`.
    - Lasts one cycle: `gen_reset=1`, the FIFO is emptied, no load is issued. Then go to IDLE.
- **Outputs**
  - `step = gen_step_stb && state==RUN`.
  - On `step`: `position` is incremented if `dir` is 1, decremented if 0. It wraps modulo 2^32.
  - `position` is not cleared by `abort`, only by `reset`.
  - `seg_done_stb` is `gen_done && state==RUN`, registered.
- **Error flag**: `clear_err` clears `err_zero`. If a set and a clear occur in the same cycle, set wins.
- **Precedence**: reset > abort > load/pop > push.
  - A push in the same cycle as `abort` is discarded.
  - An `abort` in the same cycle as `gen_done` goes to FLUSH with no load.
- **Enable deassertion**
  - Dropping `enable` mid-segment does not stop the current segment.
  - The scheduler returns to IDLE at that segment's `gen_done`.

## Timing
- **Reset values**: state IDLE, `fifo_level` 0, `position` 0, `dir` 0, `err_zero` 0, `seg_done_stb` 0.
  - `gen_reset` is 1 during reset and for the cycle after reset is deasserted.
  - `gen_load`, `step` and `busy` are 0.
- **Push-to-load latency**: a push at edge t into an empty FIFO while IDLE with `enable=1` makes `gen_load` high in cycle t+1. The generator begins counting at t+2.
- **Chaining**: `gen_load` is asserted in the same cycle as the `gen_done` of segment N. The first step of segment N+1 follows exactly `dt(N+1)` cycles after the last step of segment N.
- **`dir` timing**: `dir` updates on the edge where the load is taken. It is therefore stable before the first step of the new segment, and also at the last step of the previous segment.
- **Combinational paths**: `gen_load` is combinational from `gen_done`. `gen_dt_val` and `gen_steps_val` are driven from the FIFO head register with no logic.
- **Abort timing**: `abort` at cycle t gives `gen_reset=1` in cycle t+1 and `busy=0` from t+2.

## Test plan
- **Single segment**: reset; push {dt=4, steps=3, dir=1}; enable=1.
  - Expect 3 `step` pulses spaced 4 cycles apart.
  - Expect `position`=3, one `seg_done_stb`, and `busy`=0 after the last step.
- **Chaining**: push {dt=2, steps=2, dir=1} then {dt=3, steps=2, dir=0}.
  - Expect steps spaced 2, 2, 3, 3 with no extra gap.
  - Expect `position` 1, 2, 1, 0.
  - Expect `dir` to flip at the edge of the first segment's last step.
- **FIFO full**: enable=0; push 5 segments with FIFO_AW=2.
  - Expect `seg_ready`=0 after 4, `fifo_level`=4, and the fifth push stalled.
- **Zero segments**: push {dt=0, steps=5} and {dt=5, steps=0}.
  - Expect both handshaken, `fifo_level`=0, `err_zero`=1 until `clear_err`.
- **Abort**: pulse `abort` mid-segment with 2 segments queued.
  - Expect one `gen_reset` pulse, `fifo_level`=0, no further `step`, and `position` held.
- **Wrap and reset**:
  - From `position`=0 with dir=0, one step gives 0xFFFFFFFF.
  - Asserting `reset` mid-segment returns all outputs to their reset values.

Source files
------------

// File: rtl/motion_seg_sched.sv
`default_nettype none
// ============================================================================
// Module   : motion_seg_sched
// Purpose  : Buffers motion segments in a FIFO and chains them into the step
//            generator. Also tracks the absolute axis position.
// Revision : 1.0
// ============================================================================
module motion_seg_sched #(
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        seg_dt,
  input  logic [31:0]        seg_steps,
  input  logic               seg_dir,
  input  logic               seg_valid,
  output logic               seg_ready,
  input  logic               enable,
  input  logic               abort,
  input  logic               clear_err,
  output logic [31:0]        gen_dt_val,
  output logic [31:0]        gen_steps_val,
  output logic               gen_load,
  output logic               gen_reset,
  input  logic               gen_step_stb,
  input  logic               gen_done,
  output logic               dir,
  output logic               step,
  output logic [31:0]        position,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               seg_done_stb,
  output logic               err_zero
);

  localparam int               c_DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] c_FULL  = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [64:0]          r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_level;
  logic                 r_dir, r_gen_reset, r_seg_done, r_err;
  logic [31:0]          r_position;
  logic [64:0]          w_head;
  logic                 w_not_empty, w_push_hs, w_zero, w_wr, w_pop, w_err_set;

  assign w_head        = r_mem[r_rd_ptr];
  assign w_not_empty   = (r_level != '0);
  assign seg_ready     = (r_level != c_FULL);
  assign w_push_hs     = seg_valid && seg_ready;
  assign w_zero        = (seg_dt == 32'd0) || (seg_steps == 32'd0);
  // Zero segments are acknowledged but dropped; an abort discards any push.
  assign w_wr          = w_push_hs && !w_zero && !abort;
  assign w_err_set     = w_push_hs && w_zero && !abort;
  assign w_pop         = gen_load;

  assign gen_dt_val    = w_head[31:0];
  assign gen_steps_val = w_head[63:32];
  assign gen_reset     = r_gen_reset;
  assign dir           = r_dir;
  assign position      = r_position;
  assign fifo_level    = r_level;
  assign seg_done_stb  = r_seg_done;
  assign err_zero      = r_err;
  assign busy          = (r_state != S_IDLE);
  assign step          = gen_step_stb && (r_state == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    gen_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        gen_load = enable && w_not_empty;
        if (gen_load) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Chained load in the last-step cycle keeps segments back-to-back.
        gen_load = gen_done && enable && w_not_empty;
        if (gen_done && !gen_load) w_state_nxt = S_IDLE;
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      gen_load    = 1'b0;
      w_state_nxt = S_FLUSH;
    end
    if (reset) gen_load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_wr && !reset) r_mem[r_wr_ptr] <= {seg_dir, seg_steps, seg_dt};
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir       <= 1'b0;
      r_position  <= '0;
      r_seg_done  <= 1'b0;
      r_gen_reset <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_gen_reset <= abort;
      r_seg_done  <= gen_done && (r_state == S_RUN);
      if (gen_load) r_dir <= w_head[64];
      if (step)     r_position <= r_position + (r_dir ? 32'd1 : 32'hFFFF_FFFF);
      if (w_err_set)      r_err <= 1'b1;
      else if (clear_err) r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motion_seg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_seg_sched
// Purpose  : Self-checking bench: generator model, step-level reference queue.
// Revision : 1.0
// ============================================================================
module tb_motion_seg_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seg_dt = '0, seg_steps = '0;
  logic        seg_dir = 1'b0, seg_valid = 1'b0, enable = 1'b0;
  logic        abort = 1'b0, clear_err = 1'b0;
  logic        seg_ready, gen_load, gen_reset, dir, step, busy;
  logic        seg_done_stb, err_zero, gen_step_stb, gen_done;
  logic [31:0] gen_dt_val, gen_steps_val, position;
  logic [2:0]  fifo_level;

  motion_seg_sched #(.FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .seg_dt(seg_dt), .seg_steps(seg_steps),
    .seg_dir(seg_dir), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .enable(enable), .abort(abort), .clear_err(clear_err),
    .gen_dt_val(gen_dt_val), .gen_steps_val(gen_steps_val),
    .gen_load(gen_load), .gen_reset(gen_reset), .gen_step_stb(gen_step_stb),
    .gen_done(gen_done), .dir(dir), .step(step), .position(position),
    .busy(busy), .fifo_level(fifo_level), .seg_done_stb(seg_done_stb),
    .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  // Step generator: first step dt cycles after the load edge, then every dt.
  logic        g_act = 1'b0;
  logic [31:0] g_cnt = '0, g_rem = '0, g_dt = '0;
  assign gen_step_stb = g_act && (g_cnt == 32'd1);
  assign gen_done     = gen_step_stb && (g_rem == 32'd1);

  always @(posedge clk) begin
    if (gen_reset) g_act <= 1'b0;
    else if (gen_load) begin
      g_act <= 1'b1; g_cnt <= gen_dt_val; g_rem <= gen_steps_val; g_dt <= gen_dt_val;
    end else if (g_act) begin
      if (gen_step_stb) begin
        g_rem <= g_rem - 1;
        g_cnt <= g_dt;
        if (g_rem == 32'd1) g_act <= 1'b0;
      end else g_cnt <= g_cnt - 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every accepted segment expands into its individual steps.
  typedef struct packed {
    logic [31:0] dt;
    logic        d;
    logic        last;
  } exp_step_t;

  exp_step_t   q[$];
  logic [31:0] exp_pos = '0;
  int          exp_done = 0, obs_done = 0, cyc = 0, last_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_step_t e;
    #2;
    if (reset) begin
      q.delete();
      exp_pos = '0;
    end else begin
      if (gen_load && !busy) last_ref = cyc;
      if (step) begin
        check("step_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("step_interval", 64'(cyc - last_ref), 64'(e.dt));
          check("step_dir", 64'(dir), 64'(e.d));
          check("step_pos", 64'(position), 64'(exp_pos));
          exp_pos = e.d ? exp_pos + 32'd1 : exp_pos - 32'd1;
          if (e.last) exp_done++;
        end
        last_ref = cyc;
      end
      if (seg_done_stb) obs_done++;
      if (abort) q.delete();
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push(input logic [31:0] dt, input logic [31:0] st, input logic d);
    int n = 0;
    seg_dt = dt; seg_steps = st; seg_dir = d; seg_valid = 1'b1;
    while (!seg_ready && n < 200) begin @(negedge clk); n++; end
    check("push_ready", 64'(seg_ready), 1);
    if (seg_ready) begin
      @(posedge clk);
      if (dt != 0 && st != 0)
        for (int k = 0; k < int'(st); k++) q.push_back('{dt, d, (k == int'(st) - 1)});
      @(negedge clk);
    end
    seg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy || fifo_level != 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("idle_reached", 64'(n < 2000), 1);
    check("done_count", 64'(obs_done), 64'(exp_done));
    check("position_final", 64'(position), 64'(exp_pos));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos"}, 64'(position), 0);
    check({tag, "_level"}, 64'(fifo_level), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_dir"}, 64'(dir), 0);
    check({tag, "_err"}, 64'(err_zero), 0);
    check({tag, "_done"}, 64'(seg_done_stb), 0);
    check({tag, "_genrst"}, 64'(gen_reset), 1);
    check({tag, "_load"}, 64'(gen_load), 0);
    check({tag, "_step"}, 64'(step), 0);
  endtask

  initial begin
    logic [31:0] saved;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    check("rst_ready", 64'(seg_ready), 1);
    reset = 1'b0;
    #1 check("gen_reset_post", 64'(gen_reset), 1);
    @(negedge clk);
    check("gen_reset_low", 64'(gen_reset), 0);

    // Single segment and push-to-load latency
    enable = 1'b1;
    push(32'd4, 32'd3, 1'b1);
    check("push_to_load", 64'(gen_load), 1);
    wait_idle();
    check("single_pos", 64'(position), 3);
    check("single_busy", 64'(busy), 0);

    // Chaining
    enable = 1'b0;
    push(32'd2, 32'd2, 1'b1);
    push(32'd3, 32'd2, 1'b0);
    enable = 1'b1;
    wait_idle();
    check("chain_pos", 64'(position), 3);

    // FIFO full
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd2, 32'd1, 1'b1);
    check("full_ready", 64'(seg_ready), 0);
    check("full_level", 64'(fifo_level), 4);
    seg_dt = 32'd1; seg_steps = 32'd1; seg_dir = 1'b0; seg_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_stall", 64'(fifo_level), 4);
    seg_valid = 1'b0;
    enable = 1'b1;
    push(32'd1, 32'd1, 1'b0);
    wait_idle();
    check("full_pos", 64'(position), 6);

    // Zero segments and sticky error
    enable = 1'b0;
    push(32'd0, 32'd5, 1'b1);
    push(32'd5, 32'd0, 1'b1);
    check("zero_level", 64'(fifo_level), 0);
    check("zero_err", 64'(err_zero), 1);
    @(negedge clk);
    check("zero_err_sticky", 64'(err_zero), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("zero_err_clr", 64'(err_zero), 0);
    clear_err = 1'b1;
    push(32'd0, 32'd1, 1'b1);
    clear_err = 1'b0;
    check("err_set_wins", 64'(err_zero), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;

    // Abort mid-segment with two queued
    for (int i = 0; i < 3; i++) push(32'd3, 32'd4, 1'b1);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_genrst", 64'(gen_reset), 1);
    check("abort_level", 64'(fifo_level), 0);
    saved = position;
    @(negedge clk);
    check("abort_genrst_end", 64'(gen_reset), 0);
    check("abort_busy", 64'(busy), 0);
    repeat (30) @(negedge clk);
    check("abort_pos_held", 64'(position), 64'(saved));
    wait_idle();

    // Randomized batches
    for (int b = 0; b < 10; b++) begin
      int n;
      enable = b[0];
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        logic [31:0] dt, st;
        dt = $urandom_range(1, 4);
        st = $urandom_range(1, 3);
        if ($urandom_range(0, 7) == 0) dt = 0;
        push(dt, st, 1'($urandom_range(0, 1)));
      end
      enable = 1'b1;
      if (b == 6) begin
        repeat ($urandom_range(2, 10)) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      wait_idle();
      check("rand_level", 64'(fifo_level), 0);
    end

    // Wrap from zero, then reset mid-segment
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    push(32'd1, 32'd1, 1'b0);
    wait_idle();
    check("wrap_pos", 64'(position), 64'(32'hFFFF_FFFF));
    push(32'd5, 32'd4, 1'b1);
    push(32'd2, 32'd2, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_busy_after", 64'(busy), 0);
    check("midrst_pos_after", 64'(position), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
